multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequenced control unit for the 16-bit Unicycle core. It replaces single-cycle combinational decode with a fetch/decode/execute/memory/writeback state machine. It handshakes with separate instruction and data memory ports and holds datapath select fields stable for the whole instruction. Strobes are issued only in the commit cycle. It sits between the PC/instruction register and the datapath muxes, ALU, register file, SP/RA registers and the output line.

## Interface
Parameters:
- `SHAMT_W`, default 5: shift-amount field width, taken from `instr[10 -: SHAMT_W]`; must be ≤ 7.
- `MEM_TIMEOUT`, default 255: maximum wait cycles on either memory handshake before a bus error; 0 means wait forever.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `run` in 1: leave IDLE and begin fetching.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: fetch complete; `instr` is valid this cycle.
- `instr` in 16: instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a write.
- `dmem_ready` in 1: data access complete.
- `alu_in1_sel` out 2, `alu_in2_sel` out 2, `alu_op` out 3: ALU selects.
- `pc_out_sel` out 2, `sp_out_sel` out 1, `ra_out_sel` out 1: next-value selects.
- `mem_addr_sel` out 2, `mem_out_sel` out 1: memory address and data selects.
- `reg_out_sel` out 3: register-file writeback select.
- `shift_amount` out SHAMT_W: shift amount.
- `force_pc_alternate` out 1: take the PC alternate regardless of the comparator.
- `reg_write`, `sp_write`, `ra_write`, `output_line_write`, `pc_write` out 1 each: commit strobes.
- `busy` out 1: high in every state except IDLE and ERROR.
- `bus_error` out 1: sticky; cleared only by reset.
- `retired_count` out CNT_W: present only with `CTRL_RETIRE_COUNT_EN`.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR.

State transitions:
- IDLE: go to FETCH when `run`=1.
- FETCH: hold `imem_req` high; on `imem_ready`, latch `instr` into the internal IR and go to DECODE.
- DECODE: register all select fields from the IR, then go to EXEC.
- EXEC: go to MEM for memory-class instructions, otherwise go to WB.
- MEM: hold `dmem_req` high and drive `dmem_we`=1 for STR, STRSP and JUMP; on `dmem_ready`, go to WB.
- WB: pulse the decoded strobes and `pc_write` for one cycle. Go to FETCH if `run`=1, else IDLE.
- ERROR: entered when a wait counter reaches `MEM_TIMEOUT`; sets `bus_error`, all strobes stay 0, exit only by reset.

Decode (any field not listed is 0):
- `000`,b12=0 ALU: in1=2, in2=1, op=`instr[11:9]`, regsel=1, reg_write.
- `000`,1,0 LU: regsel=2, reg_write. `000`,1,1 LL: regsel=3, reg_write.
- `001`,0 ADDI: in1=2, regsel=1, reg_write.
- `001`,1,0 SHIFT: regsel=4, shift_amount from field, reg_write.
- `001`,1,1,0 RETURN: in1=1, pcsel=2, addrsel=2, sp_write, ra_write, force; memory read.
- `001`,1,1,1 JUMP: pcsel=1, rasel=1, addrsel=1, outsel=1, ra_write, force; memory write.
- `010`,0 STRSP: in1=1, addrsel=1; memory write. `010`,1 RTVSP: in1=1, reg_write.
- `011`, b12:10=`100`:
  - b9:6=`0010` STR: memory write.
  - b9:6=`0011` RTV: reg_write; memory read.
  - otherwise, b5:3=0 READ: regsel=7, reg_write.
  - otherwise WRITE: output_line_write.
- `011`, b12:10=`101`, by b9:3:
  - `0000000` GETSP: regsel=5, reg_write.
  - `0100000` CHGSP: in1=1, in2=2, sp_write.
  - `0100001` SETSP: spsel=1, sp_write.
  - `1000000` GETPC: regsel=6, reg_write.
  - `1100000` CHGPC: in2=2, pcsel=1, force.
  - otherwise SETPC: pcsel=3, force.
- `011`, b12:10=`110` CHGSPI: in1=1, sp_write.
- `011`, any other b12:10 CHGPCI: pcsel=1, force.
- `1xx` branches (EQ/NEQ/LT/GEQ): pcsel=1, no force.

Output behaviour:
- Select fields and `force_pc_alternate` change only on the DECODE edge and hold through WB.
- `pc_write` pulses in every WB.

## Timing
- Reset (async): state IDLE; every output 0, including `retired_count` and `bus_error`.
- Latency with a zero-wait `imem_ready`: non-memory instruction 4 cycles (FETCH, DECODE, EXEC, WB); memory instruction 5 cycles.
- Each wait cycle adds one cycle.
- Request hold: `imem_req`/`dmem_req` stay high until the cycle in which ready is sampled high, then drop on the next edge.
- Ready outside FETCH/MEM is ignored.
- Wait counter: clears on entry to FETCH or MEM. With `MEM_TIMEOUT`=N, ready absent for N consecutive request cycles causes the edge after the Nth cycle to enter ERROR.
- Ready sampled in the same cycle as the timeout: ready wins.
- `run` deassert mid-instruction: the instruction completes; the FSM stops at the end of WB.
- Reset mid-MEM: `dmem_req` drops immediately (asynchronously); no strobe is issued.

## Configuration
- `CTRL_RETIRE_COUNT_EN` defined: `retired_count` increments by 1 on every WB edge and wraps modulo 2^CNT_W.
- Undefined: the port is absent and no counter logic is present.

## Test plan
- Reset, `run`=1, ADDI `0x2000`, zero-wait: `imem_req` 1 cycle; `reg_write`=1 and `reg_out_sel`=1 exactly on cycle 4; `dmem_req` never asserted.
- STR `0x7088`, `dmem_ready` delayed 3 cycles: `dmem_req`=1 and `dmem_we`=1 for 4 cycles; `pc_write` on cycle 8; `reg_write`=0 throughout.
- JUMP `0x3C00`: `pc_out_sel`=1, `ra_out_sel`=1, `mem_out_sel`=1 and `force_pc_alternate`=1 held from DECODE to WB; `ra_write`=1 in WB only.
- `MEM_TIMEOUT`=4, RTV `0x70C0`, `dmem_ready` held 0: ERROR after 4 request cycles; `bus_error`=1; `busy`=0; no further `imem_req`.
- Reset asserted mid-MEM: all outputs 0 immediately; FETCH restarts after reset release with `run`=1.
- `CTRL_RETIRE_COUNT_EN`, `CNT_W`=4, 17 instructions: `retired_count`=1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer for the 16-bit Unicycle core: fetch/decode/exec/mem/writeback with memory handshakes.
// Optional retired-instruction counter is enabled by defining CTRL_RETIRE_COUNT_EN.
module multicycle_control_fsm #(
    parameter int SHAMT_W     = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [15:0]        instr,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    output logic [1:0]         alu_in1_sel,
    output logic [1:0]         alu_in2_sel,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_out_sel,
    output logic               sp_out_sel,
    output logic               ra_out_sel,
    output logic [1:0]         mem_addr_sel,
    output logic               mem_out_sel,
    output logic [2:0]         reg_out_sel,
    output logic [SHAMT_W-1:0] shift_amount,
    output logic               force_pc_alternate,
    output logic               reg_write,
    output logic               sp_write,
    output logic               ra_write,
    output logic               output_line_write,
    output logic               pc_write,
    output logic               busy,
    output logic               bus_error
`ifdef CTRL_RETIRE_COUNT_EN
    ,
    output logic [CNT_W-1:0]   retired_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [15:0] ir_reg;
    logic timeout_hit;

    // Decoded fields, combinational from the IR
    logic [1:0]         dec_in1, dec_in2, dec_pcsel, dec_addrsel;
    logic [2:0]         dec_op, dec_regsel;
    logic               dec_spsel, dec_rasel, dec_outsel, dec_force;
    logic [SHAMT_W-1:0] dec_shamt;
    logic               dec_rw, dec_sw, dec_raw, dec_olw, dec_mem, dec_we;

    // Decoded fields, held from the DECODE edge through WB
    logic [1:0]         in1_reg, in2_reg, pcsel_reg, addrsel_reg;
    logic [2:0]         op_reg, regsel_reg;
    logic               spsel_reg, rasel_reg, outsel_reg, force_reg;
    logic [SHAMT_W-1:0] shamt_reg;
    logic               rw_reg, sw_reg, raw_reg, olw_reg, mem_reg, we_reg;

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_reg[2:0];

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH: begin
                // ready beats a timeout landing in the same cycle
                if (imem_ready)       state_next = S_DECODE;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = mem_reg ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready)       state_next = S_WB;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_WB:     state_next = run ? S_FETCH : S_IDLE;
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_IDLE;
        endcase
    end

    // Counts consecutive request cycles without ready; any state change clears it
    always_comb begin
        wait_cnt_next = '0;
        if ((state_reg == S_FETCH || state_reg == S_MEM) && state_next == state_reg)
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end

    always_comb begin
        imem_req          = 1'b0;
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        busy              = 1'b0;
        bus_error         = 1'b0;
        reg_write         = 1'b0;
        sp_write          = 1'b0;
        ra_write          = 1'b0;
        output_line_write = 1'b0;
        pc_write          = 1'b0;
        case (state_reg)
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
            end
            S_DECODE, S_EXEC: busy = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = we_reg;
                busy     = 1'b1;
            end
            S_WB: begin
                busy              = 1'b1;
                reg_write         = rw_reg;
                sp_write          = sw_reg;
                ra_write          = raw_reg;
                output_line_write = olw_reg;
                pc_write          = 1'b1;
            end
            S_ERROR: bus_error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir_reg <= '0;
        else if (state_reg == S_FETCH && imem_ready)
            ir_reg <= instr;
    end

    always_comb begin
        dec_in1     = '0;
        dec_in2     = '0;
        dec_op      = '0;
        dec_pcsel   = '0;
        dec_spsel   = 1'b0;
        dec_rasel   = 1'b0;
        dec_addrsel = '0;
        dec_outsel  = 1'b0;
        dec_regsel  = '0;
        dec_shamt   = '0;
        dec_force   = 1'b0;
        dec_rw      = 1'b0;
        dec_sw      = 1'b0;
        dec_raw     = 1'b0;
        dec_olw     = 1'b0;
        dec_mem     = 1'b0;
        dec_we      = 1'b0;
        case (ir_reg[15:13])
            3'b000: begin
                dec_rw = 1'b1;
                if (!ir_reg[12]) begin
                    dec_in1    = 2'd2;
                    dec_in2    = 2'd1;
                    dec_op     = ir_reg[11:9];
                    dec_regsel = 3'd1;
                end else begin
                    dec_regsel = ir_reg[11] ? 3'd3 : 3'd2;
                end
            end
            3'b001: begin
                if (!ir_reg[12]) begin
                    dec_in1    = 2'd2;
                    dec_regsel = 3'd1;
                    dec_rw     = 1'b1;
                end else if (!ir_reg[11]) begin
                    dec_regsel = 3'd4;
                    dec_shamt  = ir_reg[10 -: SHAMT_W];
                    dec_rw     = 1'b1;
                end else if (!ir_reg[10]) begin
                    // RETURN: pop RA from the stack
                    dec_in1     = 2'd1;
                    dec_pcsel   = 2'd2;
                    dec_addrsel = 2'd2;
                    dec_sw      = 1'b1;
                    dec_raw     = 1'b1;
                    dec_force   = 1'b1;
                    dec_mem     = 1'b1;
                end else begin
                    // JUMP: push RA and take the target
                    dec_pcsel   = 2'd1;
                    dec_rasel   = 1'b1;
                    dec_addrsel = 2'd1;
                    dec_outsel  = 1'b1;
                    dec_raw     = 1'b1;
                    dec_force   = 1'b1;
                    dec_mem     = 1'b1;
                    dec_we      = 1'b1;
                end
            end
            3'b010: begin
                dec_in1 = 2'd1;
                if (!ir_reg[12]) begin
                    dec_addrsel = 2'd1;
                    dec_mem     = 1'b1;
                    dec_we      = 1'b1;
                end else begin
                    dec_rw = 1'b1;
                end
            end
            3'b011: begin
                case (ir_reg[12:10])
                    3'b100: begin
                        if (ir_reg[9:6] == 4'b0010) begin
                            dec_mem = 1'b1;
                            dec_we  = 1'b1;
                        end else if (ir_reg[9:6] == 4'b0011) begin
                            dec_rw  = 1'b1;
                            dec_mem = 1'b1;
                        end else if (ir_reg[5:3] == 3'b000) begin
                            dec_regsel = 3'd7;
                            dec_rw     = 1'b1;
                        end else begin
                            dec_olw = 1'b1;
                        end
                    end
                    3'b101: begin
                        case (ir_reg[9:3])
                            7'b0000000: begin
                                dec_regsel = 3'd5;
                                dec_rw     = 1'b1;
                            end
                            7'b0100000: begin
                                dec_in1 = 2'd1;
                                dec_in2 = 2'd2;
                                dec_sw  = 1'b1;
                            end
                            7'b0100001: begin
                                dec_spsel = 1'b1;
                                dec_sw    = 1'b1;
                            end
                            7'b1000000: begin
                                dec_regsel = 3'd6;
                                dec_rw     = 1'b1;
                            end
                            7'b1100000: begin
                                dec_in2   = 2'd2;
                                dec_pcsel = 2'd1;
                                dec_force = 1'b1;
                            end
                            default: begin
                                dec_pcsel = 2'd3;
                                dec_force = 1'b1;
                            end
                        endcase
                    end
                    3'b110: begin
                        dec_in1 = 2'd1;
                        dec_sw  = 1'b1;
                    end
                    default: begin
                        dec_pcsel = 2'd1;
                        dec_force = 1'b1;
                    end
                endcase
            end
            // conditional branches: the comparator decides, no force
            default: dec_pcsel = 2'd1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in1_reg     <= '0;
            in2_reg     <= '0;
            op_reg      <= '0;
            pcsel_reg   <= '0;
            spsel_reg   <= 1'b0;
            rasel_reg   <= 1'b0;
            addrsel_reg <= '0;
            outsel_reg  <= 1'b0;
            regsel_reg  <= '0;
            shamt_reg   <= '0;
            force_reg   <= 1'b0;
            rw_reg      <= 1'b0;
            sw_reg      <= 1'b0;
            raw_reg     <= 1'b0;
            olw_reg     <= 1'b0;
            mem_reg     <= 1'b0;
            we_reg      <= 1'b0;
        end else if (state_reg == S_DECODE) begin
            in1_reg     <= dec_in1;
            in2_reg     <= dec_in2;
            op_reg      <= dec_op;
            pcsel_reg   <= dec_pcsel;
            spsel_reg   <= dec_spsel;
            rasel_reg   <= dec_rasel;
            addrsel_reg <= dec_addrsel;
            outsel_reg  <= dec_outsel;
            regsel_reg  <= dec_regsel;
            shamt_reg   <= dec_shamt;
            force_reg   <= dec_force;
            rw_reg      <= dec_rw;
            sw_reg      <= dec_sw;
            raw_reg     <= dec_raw;
            olw_reg     <= dec_olw;
            mem_reg     <= dec_mem;
            we_reg      <= dec_we;
        end
    end

    assign alu_in1_sel        = in1_reg;
    assign alu_in2_sel        = in2_reg;
    assign alu_op             = op_reg;
    assign pc_out_sel         = pcsel_reg;
    assign sp_out_sel         = spsel_reg;
    assign ra_out_sel         = rasel_reg;
    assign mem_addr_sel       = addrsel_reg;
    assign mem_out_sel        = outsel_reg;
    assign reg_out_sel        = regsel_reg;
    assign shift_amount       = shamt_reg;
    assign force_pc_alternate = force_reg;

`ifdef CTRL_RETIRE_COUNT_EN
    logic [CNT_W-1:0] retired_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retired_count_reg <= '0;
        else if (state_reg == S_WB)
            retired_count_reg <= retired_count_reg + CNT_W'(1);
    end

    assign retired_count = retired_count_reg;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction cycle schedule model plus a mnemonic-level decode table.
// Build with CTRL_RETIRE_COUNT_EN defined to also check the retired-instruction counter.
module tb_multicycle_control_fsm;

    localparam int SHAMT_W     = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic clk = 1'b0;
    logic reset, run, imem_ready, dmem_ready;
    logic [15:0] instr;
    logic imem_req, dmem_req, dmem_we;
    logic [1:0] alu_in1_sel, alu_in2_sel, pc_out_sel, mem_addr_sel;
    logic [2:0] alu_op, reg_out_sel;
    logic sp_out_sel, ra_out_sel, mem_out_sel, force_pc_alternate;
    logic [SHAMT_W-1:0] shift_amount;
    logic reg_write, sp_write, ra_write, output_line_write, pc_write, busy, bus_error;
`ifdef CTRL_RETIRE_COUNT_EN
    logic [CNT_W-1:0] retired_count;
    bit pending17 = 0;
`endif

    always #5 clk = ~clk;

    multicycle_control_fsm #(.SHAMT_W(SHAMT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .alu_in1_sel(alu_in1_sel), .alu_in2_sel(alu_in2_sel), .alu_op(alu_op),
        .pc_out_sel(pc_out_sel), .sp_out_sel(sp_out_sel), .ra_out_sel(ra_out_sel),
        .mem_addr_sel(mem_addr_sel), .mem_out_sel(mem_out_sel), .reg_out_sel(reg_out_sel),
        .shift_amount(shift_amount), .force_pc_alternate(force_pc_alternate),
        .reg_write(reg_write), .sp_write(sp_write), .ra_write(ra_write),
        .output_line_write(output_line_write), .pc_write(pc_write),
        .busy(busy), .bus_error(bus_error)
`ifdef CTRL_RETIRE_COUNT_EN
        , .retired_count(retired_count)
`endif
    );

    typedef enum {
        M_ALU, M_LU, M_LL, M_ADDI, M_SHIFT, M_RETURN, M_JUMP, M_STRSP, M_RTVSP,
        M_STR, M_RTV, M_READ, M_WRITE, M_GETSP, M_CHGSP, M_SETSP, M_GETPC,
        M_CHGPC, M_SETPC, M_CHGSPI, M_CHGPCI, M_BRANCH
    } mn_t;

    typedef struct packed {
        logic [1:0] in1, in2;
        logic [2:0] op;
        logic [1:0] pcsel;
        logic       spsel, rasel;
        logic [1:0] addrsel;
        logic       outsel;
        logic [2:0] regsel;
        logic [4:0] shamt;
        logic       force_pc;
        logic       rw, sw, raw, olw;
        logic       mem, we;
    } fields_t;

    int total = 0;
    int bad = 0;
    int wb_count = 0;
    fields_t prev_f = '0;

    logic [32:0] act_vec;
    assign act_vec = {imem_req, dmem_req, dmem_we, busy, bus_error, alu_in1_sel, alu_in2_sel,
                      alu_op, pc_out_sel, sp_out_sel, ra_out_sel, mem_addr_sel, mem_out_sel,
                      reg_out_sel, shift_amount, force_pc_alternate, reg_write, sp_write,
                      ra_write, output_line_write, pc_write};

    function automatic mn_t classify(input logic [15:0] i);
        if (i[15]) return M_BRANCH;
        case (i[14:13])
            2'b00: return !i[12] ? M_ALU : (i[11] ? M_LL : M_LU);
            2'b01: begin
                if (!i[12]) return M_ADDI;
                if (!i[11]) return M_SHIFT;
                return i[10] ? M_JUMP : M_RETURN;
            end
            2'b10: return i[12] ? M_RTVSP : M_STRSP;
            default: begin
                if (i[12:10] == 3'b100) begin
                    if (i[9:6] == 4'b0010) return M_STR;
                    if (i[9:6] == 4'b0011) return M_RTV;
                    return (i[5:3] == 3'b000) ? M_READ : M_WRITE;
                end
                if (i[12:10] == 3'b101) begin
                    if (i[9:3] == 7'b0000000) return M_GETSP;
                    if (i[9:3] == 7'b0100000) return M_CHGSP;
                    if (i[9:3] == 7'b0100001) return M_SETSP;
                    if (i[9:3] == 7'b1000000) return M_GETPC;
                    if (i[9:3] == 7'b1100000) return M_CHGPC;
                    return M_SETPC;
                end
                return (i[12:10] == 3'b110) ? M_CHGSPI : M_CHGPCI;
            end
        endcase
    endfunction

    function automatic fields_t model(input logic [15:0] i);
        fields_t f;
        f = '0;
        case (classify(i))
            M_ALU:    begin f.in1 = 2; f.in2 = 1; f.op = i[11:9]; f.regsel = 1; f.rw = 1; end
            M_LU:     begin f.regsel = 2; f.rw = 1; end
            M_LL:     begin f.regsel = 3; f.rw = 1; end
            M_ADDI:   begin f.in1 = 2; f.regsel = 1; f.rw = 1; end
            M_SHIFT:  begin f.regsel = 4; f.shamt = i[10:6]; f.rw = 1; end
            M_RETURN: begin f.in1 = 1; f.pcsel = 2; f.addrsel = 2; f.sw = 1; f.raw = 1;
                            f.force_pc = 1; f.mem = 1; end
            M_JUMP:   begin f.pcsel = 1; f.rasel = 1; f.addrsel = 1; f.outsel = 1; f.raw = 1;
                            f.force_pc = 1; f.mem = 1; f.we = 1; end
            M_STRSP:  begin f.in1 = 1; f.addrsel = 1; f.mem = 1; f.we = 1; end
            M_RTVSP:  begin f.in1 = 1; f.rw = 1; end
            M_STR:    begin f.mem = 1; f.we = 1; end
            M_RTV:    begin f.rw = 1; f.mem = 1; end
            M_READ:   begin f.regsel = 7; f.rw = 1; end
            M_WRITE:  f.olw = 1;
            M_GETSP:  begin f.regsel = 5; f.rw = 1; end
            M_CHGSP:  begin f.in1 = 1; f.in2 = 2; f.sw = 1; end
            M_SETSP:  begin f.spsel = 1; f.sw = 1; end
            M_GETPC:  begin f.regsel = 6; f.rw = 1; end
            M_CHGPC:  begin f.in2 = 2; f.pcsel = 1; f.force_pc = 1; end
            M_SETPC:  begin f.pcsel = 3; f.force_pc = 1; end
            M_CHGSPI: begin f.in1 = 1; f.sw = 1; end
            M_CHGPCI: begin f.pcsel = 1; f.force_pc = 1; end
            default:  f.pcsel = 1;
        endcase
        return f;
    endfunction

    function automatic logic [32:0] mk_exp(input logic ireq, input logic dreq, input logic we,
                                           input logic bsy, input logic berr, input fields_t f,
                                           input logic wb);
        return {ireq, dreq, we, bsy, berr, f.in1, f.in2, f.op, f.pcsel, f.spsel, f.rasel,
                f.addrsel, f.outsel, f.regsel, f.shamt, f.force_pc,
                wb & f.rw, wb & f.sw, wb & f.raw, wb & f.olw, wb};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_f(input string name, input fields_t act, input fields_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: model gave %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle_check(input string name, input logic [32:0] exp);
        chk(name, act_vec, exp);
`ifdef CTRL_RETIRE_COUNT_EN
        total++;
        if (retired_count !== CNT_W'(wb_count)) begin
            bad++;
            $display("FAIL %s_retired: got %0d want %0d", name, retired_count, CNT_W'(wb_count));
        end
        if (pending17) begin
            pending17 = 0;
            total++;
            if (retired_count !== 4'd1) begin
                bad++;
                $display("FAIL retired_after_17: got %0d want 1", retired_count);
            end
        end
`endif
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cycle_check("idle", mk_exp(0, 0, 0, 0, 0, prev_f, 0));
            run        = (k == n - 1);
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            instr      = 16'($urandom);
        end
    endtask

    // One instruction starting in FETCH: iw/dw are wait cycles before ready on each port.
    task automatic run_instr(input logic [15:0] ins, input int iw, input int dw, input logic run_after);
        fields_t f;
        int flen, mlen, tot;
        f    = model(ins);
        flen = iw + 1;
        mlen = f.mem ? dw + 1 : 0;
        tot  = flen + 2 + mlen + 1;
        for (int k = 0; k < tot; k++) begin
            bit in_f, in_m, in_w;
            in_f = (k < flen);
            in_m = f.mem && (k >= flen + 2) && (k < flen + 2 + mlen);
            in_w = (k == tot - 1);
            @(negedge clk);
            cycle_check("cycle", mk_exp(in_f, in_m, in_m & f.we, 1, 0, (k <= flen) ? prev_f : f, in_w));
            imem_ready = in_f ? (k == iw) : 1'($urandom_range(0, 1));
            instr      = (in_f && k == iw) ? ins : 16'($urandom);
            dmem_ready = in_m ? (k == flen + 2 + dw) : 1'($urandom_range(0, 1));
            run        = in_w ? run_after : 1'($urandom_range(0, 1));
        end
        prev_f = f;
        wb_count++;
`ifdef CTRL_RETIRE_COUNT_EN
        if (wb_count == 17) pending17 = 1;
`endif
        $display("txn %s instr=%h iw=%0d dw=%0d run_next=%0d retired=%0d",
                 classify(ins).name(), ins, iw, dw, run_after, wb_count);
    endtask

    task automatic reset_pulse(input string name);
        @(negedge clk);
        reset = 1'b1;
        prev_f = '0;
        wb_count = 0;
        #1;
        cycle_check(name, '0);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
    endtask

    task automatic mid_mem_reset(input logic [15:0] ins, input int iw);
        fields_t f;
        int flen;
        f    = model(ins);
        flen = iw + 1;
        for (int k = 0; k <= flen + 2; k++) begin
            @(negedge clk);
            cycle_check("pre_rst", mk_exp(k < flen, k == flen + 2, (k == flen + 2) & f.we, 1, 0,
                                          (k <= flen) ? prev_f : f, 0));
            imem_ready = (k == iw);
            instr      = ins;
            dmem_ready = 1'b0;
            run        = 1'b1;
        end
        #2;
        reset = 1'b1;
        prev_f = '0;
        wb_count = 0;
        #1;
        cycle_check("rst_mid_mem", '0);
        $display("txn reset during MEM of %s instr=%h", classify(ins).name(), ins);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
    endtask

    task automatic timeout_instr(input logic [15:0] ins, input int iw);
        fields_t f;
        int flen;
        f    = model(ins);
        flen = iw + 1;
        for (int k = 0; k < flen + 2 + MEM_TIMEOUT; k++) begin
            bit in_f, in_m;
            in_f = (k < flen);
            in_m = (k >= flen + 2);
            @(negedge clk);
            cycle_check("to_wait", mk_exp(in_f, in_m, in_m & f.we, 1, 0, (k <= flen) ? prev_f : f, 0));
            imem_ready = in_f ? (k == iw) : 1'($urandom_range(0, 1));
            instr      = ins;
            dmem_ready = in_m ? 1'b0 : 1'($urandom_range(0, 1));
            run        = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cycle_check("error_hold", mk_exp(0, 0, 0, 0, 1, f, 0));
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            run        = 1'b1;
        end
        prev_f = f;
        $display("txn timeout %s instr=%h -> bus_error", classify(ins).name(), ins);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] i;
        logic [6:0] pk;
        i = 16'($urandom);
        case ($urandom_range(0, 3))
            0: begin
                i[15:10] = 6'b011100;
                if ($urandom_range(0, 1) == 1) i[9:6] = 4'b0010 + 4'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) i[5:3] = 3'b000;
            end
            1: begin
                i[15:10] = 6'b011101;
                case ($urandom_range(0, 5))
                    0: pk = 7'b0000000;
                    1: pk = 7'b0100000;
                    2: pk = 7'b0100001;
                    3: pk = 7'b1000000;
                    4: pk = 7'b1100000;
                    default: pk = 7'($urandom);
                endcase
                i[9:3] = pk;
            end
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        fields_t e;
        reset = 1'b1;
        run = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        instr = '0;

        @(negedge clk);
        cycle_check("reset_state", '0);
        reset = 1'b0;
        idle_cycles(2);

        e = '0; e.in1 = 2; e.regsel = 1; e.rw = 1;
        chk_f("pin_addi", model(16'h2000), e);
        e = '0; e.mem = 1; e.we = 1;
        chk_f("pin_str", model(16'h7088), e);
        e = '0; e.pcsel = 1; e.rasel = 1; e.addrsel = 1; e.outsel = 1; e.raw = 1;
        e.force_pc = 1; e.mem = 1; e.we = 1;
        chk_f("pin_jump", model(16'h3C00), e);
        e = '0; e.rw = 1; e.mem = 1;
        chk_f("pin_rtv", model(16'h70C0), e);
        e = '0; e.regsel = 4; e.shamt = 5'd21; e.rw = 1;
        chk_f("pin_shift", model(16'h3540), e);
        e = '0; e.regsel = 6; e.rw = 1;
        chk_f("pin_getpc", model(16'h7600), e);

        run_instr(16'h2000, 0, 0, 1'b1);
        run_instr(16'h7088, 0, 3, 1'b1);
        run_instr(16'h3C00, 1, 2, 1'b1);
        run_instr(16'h70C0, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0);
        idle_cycles(3);

        for (int n = 0; n < 60; n++) begin
            logic ra;
            ra = ($urandom_range(0, 3) != 0);
            run_instr(rand_instr(), $urandom_range(0, MEM_TIMEOUT - 1),
                      $urandom_range(0, MEM_TIMEOUT - 1), ra);
            if (!ra) idle_cycles($urandom_range(1, 3));
        end

        mid_mem_reset(16'h7088, 1);
        run_instr(16'h2000, 0, 0, 1'b1);
        run_instr(rand_instr(), 2, 1, 1'b1);
        timeout_instr(16'h70C0, 0);
        reset_pulse("reset_after_error");
        run_instr(16'h3C00, 0, 0, 1'b0);
        idle_cycles(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
